cpu_phase_sequencer: RTL

Single-clock replacement for the fixed 4x-clock/divider arrangement of the single-cycle CPU top. It derives a parametrised number of memory phases per CPU cycle from one base clock and drives the CPU advance strobe. It restricts data-memory writes to the late phases of each CPU cycle. It adds halt and single-step execution modes plus a retired-cycle counter, and sits in the top level between the button/IO logic, the CPU and DMem.

---
 rtl/cpu_phase_sequencer_pkg.sv | 21 ++
 rtl/cpu_phase_sequencer_edge.sv | 22 ++
 rtl/cpu_phase_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared types and default constants for the CPU phase sequencer.
package cpu_phase_sequencer_pkg;

  // Sequencer states: free run, parked at phase 0, or one single-stepped CPU cycle.
  typedef enum logic [1:0] {
    SEQ_RUN  = 2'd0,
    SEQ_IDLE = 2'd1,
    SEQ_STEP = 2'd2
  } SeqState;

  // Defaults used when the sequencer is instantiated in the CPU top level.
  localparam int SEQ_PHASES            = 4;
  localparam int SEQ_WR_FIRST_PHASE    = 2;
  localparam int SEQ_CYCLE_COUNT_WIDTH = 32;

  // True when a phase/write-window parameter pair describes a usable sequencer.
  function automatic bit seqParamsLegal(input int phases, input int wrFirstPhase);
    return (phases >= 2) && (wrFirstPhase >= 1) && (wrFirstPhase <= phases - 1);
  endfunction

endpackage

// File: rtl/cpu_phase_sequencer_edge.sv
// Rising-edge detector for an already-debounced level; also used for buttons.
module EdgeDetector (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic levelPrev_q;

  // Remember last cycle's level so a held input produces a single rise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      levelPrev_q <= 1'b0;
    end else begin
      levelPrev_q <= level;
    end
  end

  assign rise = level & ~levelPrev_q;

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Derives PHASES memory phases per CPU cycle from one base clock, issues the
// CPU advance strobe, confines DMem writes to late phases and supports halt
// and single-step execution with a retired-cycle counter.
module cpu_phase_sequencer
  import cpu_phase_sequencer_pkg::*;
#(
  parameter int PHASES            = SEQ_PHASES,
  parameter int WR_FIRST_PHASE    = SEQ_WR_FIRST_PHASE,
  parameter int CYCLE_COUNT_WIDTH = SEQ_CYCLE_COUNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stepMode,
  input  logic                         stepReq,
  input  logic                         haltReq,
  input  logic                         dataWE_FromCPU,
  output logic [$clog2(PHASES)-1:0]    phase,
  output logic                         cpuEnable,
  output logic                         dmemWrEnable,
  output logic                         running,
  output logic [CYCLE_COUNT_WIDTH-1:0] cycleCount
);

  localparam int PW = $clog2(PHASES);
  localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);
  localparam logic [PW-1:0] WR_FIRST   = PW'(WR_FIRST_PHASE);

  // Refuse to build a sequencer whose write window or phase count is meaningless.
  generate
    if (!seqParamsLegal(PHASES, WR_FIRST_PHASE)) begin : gBadParams
      $error("cpu_phase_sequencer: PHASES must be >= 2 and WR_FIRST_PHASE in 1..PHASES-1");
    end
  endgenerate

  SeqState                      state_q;
  logic [PW-1:0]                phase_q;
  logic [CYCLE_COUNT_WIDTH-1:0] cycleCount_q;
  logic [CYCLE_COUNT_WIDTH-1:0] cycleCount_d;
  logic                         stepRise;
  logic                         atLastPhase;
  logic                         cycleActive;

  EdgeDetector uStepEdge (
    .clk   (clk),
    .rst   (rst),
    .level (stepReq),
    .rise  (stepRise)
  );

  assign atLastPhase = (phase_q == LAST_PHASE);
  assign cycleActive = (state_q != SEQ_IDLE);

  // Strobes are pure decodes so they fall in the very cycle reset is asserted;
  // running is also masked by reset so nothing looks busy while held in reset.
  assign cpuEnable    = rst & cycleActive & atLastPhase;
  assign dmemWrEnable = rst & cycleActive & dataWE_FromCPU & (phase_q >= WR_FIRST);
  assign running      = rst & cycleActive;
  assign phase        = phase_q;
  assign cycleCount   = cycleCount_q;

  assign cycleCount_d = cpuEnable ? (cycleCount_q + CYCLE_COUNT_WIDTH'(1)) : cycleCount_q;

  // Phase FSM: halt and step mode are only looked at on a cycle boundary or in
  // IDLE so a CPU cycle that has started always runs to completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SEQ_RUN;
      phase_q <= '0;
    end else begin
      case (state_q)
        SEQ_RUN: begin
          if (atLastPhase) begin
            phase_q <= '0;
            state_q <= (haltReq || stepMode) ? SEQ_IDLE : SEQ_RUN;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        SEQ_IDLE: begin
          phase_q <= '0;
          if (haltReq) begin
            state_q <= SEQ_IDLE;
          end else if (!stepMode) begin
            state_q <= SEQ_RUN;
          end else if (stepRise) begin
            state_q <= SEQ_STEP;
          end else begin
            state_q <= SEQ_IDLE;
          end
        end
        SEQ_STEP: begin
          if (atLastPhase) begin
            phase_q <= '0;
            state_q <= SEQ_IDLE;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        default: begin
          phase_q <= '0;
          state_q <= SEQ_RUN;
        end
      endcase
    end
  end

  // Retired-cycle counter advances on the edge that closes each cpuEnable cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycleCount_q <= '0;
    end else begin
      cycleCount_q <= cycleCount_d;
    end
  end

endmodule
